// File: rtl/exc_pkg.sv
// Shared types and constants for the exception PC controller.
// Latency: none, declarations only.
// Backpressure: not applicable.
package exc_pkg;

  // Controller states: idle, save EPC, fetch vector byte, load PC.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SAVE  = 2'd1,
    ST_FETCH = 2'd2,
    ST_LOAD  = 2'd3
  } exc_state_e;

  // Cause codes, also the value driven on exc_cause_o.
  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'b00,
    CAUSE_OPCODE = 2'b01,
    CAUSE_OVF    = 2'b10,
    CAUSE_DIV0   = 2'b11
  } exc_cause_e;

  // PC-source mux selects shared with the main datapath.
  localparam logic [2:0] PC_SRC_ALU_DIRECT = 3'b000;
  localparam logic [2:0] PC_SRC_ALU_OUT    = 3'b001;
  localparam logic [2:0] PC_SRC_SHIFT2     = 3'b010;
  localparam logic [2:0] PC_SRC_MEM_SEXT   = 3'b011;
  localparam logic [2:0] PC_SRC_EPC        = 3'b100;

  // Default vector-table byte addresses and EPC adjustment.
  localparam logic [31:0] DEF_VEC_OPCODE = 32'd253;
  localparam logic [31:0] DEF_VEC_OVF    = 32'd254;
  localparam logic [31:0] DEF_VEC_DIV0   = 32'd255;
  localparam logic [31:0] DEF_PC_ADJUST  = 32'd4;

  // Default FETCH wait limit when the timeout feature is built in.
  localparam logic [7:0]  DEF_TIMEOUT    = 8'd16;

  // Sign-extend a vector byte into a full PC value.
  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder of exception requests: opcode > overflow > div0.
// Latency: combinational.
// Backpressure: none; the caller decides when the result is sampled.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic       exc_opcode_i,
  input  logic       exc_ovf_i,
  input  logic       exc_div0_i,
  output exc_cause_e cause_o,
  output logic       valid_o
);

  // Highest-priority request wins; valid drops when nothing is requested.
  always_comb begin
    cause_o = CAUSE_NONE;
    valid_o = 1'b1;
    if (exc_opcode_i) begin
      cause_o = CAUSE_OPCODE;
    end else if (exc_ovf_i) begin
      cause_o = CAUSE_OVF;
    end else if (exc_div0_i) begin
      cause_o = CAUSE_DIV0;
    end else begin
      valid_o = 1'b0;
    end
  end

endmodule

// File: rtl/exception_pc_ctrl.sv
// Exception entry / RTE control of PC source select and PC write; optional FETCH timeout under EXC_TIMEOUT_EN.
// Latency: exception request to pc_wr_o = 3 + memory wait cycles; rte to pc_wr_o = 1 cycle; all outputs registered.
// Backpressure: FETCH holds mem_rd_o/mem_addr_o until mem_valid_i; requests arriving while busy_o=1 are dropped.
module exception_pc_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] VEC_OPCODE = DEF_VEC_OPCODE,
  parameter logic [31:0] VEC_OVF    = DEF_VEC_OVF,
  parameter logic [31:0] VEC_DIV0   = DEF_VEC_DIV0,
  parameter logic [31:0] PC_ADJUST  = DEF_PC_ADJUST
`ifdef EXC_TIMEOUT_EN
  ,
  parameter logic [7:0]  TIMEOUT    = DEF_TIMEOUT
`endif
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        exc_opcode_i,
  input  logic        exc_ovf_i,
  input  logic        exc_div0_i,
  input  logic        rte_i,
  input  logic [31:0] pc_in_i,
  output logic        mem_rd_o,
  output logic [31:0] mem_addr_o,
  input  logic [7:0]  mem_rdata_i,
  input  logic        mem_valid_i,
  output logic [31:0] epc_out_o,
  output logic [31:0] handler_addr_o,
  output logic [2:0]  pc_src_sel_o,
  output logic        pc_wr_o,
  output logic [1:0]  exc_cause_o,
  output logic        busy_o
`ifdef EXC_TIMEOUT_EN
  ,
  output logic        exc_fault_o
`endif
);

  exc_state_e  state_q, state_d;
  exc_cause_e  cause_q, cause_d;
  exc_cause_e  enc_cause;
  logic        enc_vld;
  logic [31:0] epc_q, epc_d;
  logic [31:0] handler_q, handler_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        mem_rd_q, mem_rd_d;
  logic        pc_wr_q, pc_wr_d;
  logic [2:0]  pc_src_q, pc_src_d;
  logic        busy_q, busy_d;
`ifdef EXC_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
  logic        fault_q, fault_d;
`endif

  exc_prio_enc u_prio_enc (
    .exc_opcode_i (exc_opcode_i),
    .exc_ovf_i    (exc_ovf_i),
    .exc_div0_i   (exc_div0_i),
    .cause_o      (enc_cause),
    .valid_o      (enc_vld)
  );

  // Vector-table byte address for a latched cause.
  function automatic logic [31:0] vec_for(input exc_cause_e c);
    case (c)
      CAUSE_OPCODE: return VEC_OPCODE;
      CAUSE_OVF:    return VEC_OVF;
      CAUSE_DIV0:   return VEC_DIV0;
      default:      return 32'd0;
    endcase
  endfunction

  // Next-state and next-output logic; pc_wr/pc_src default to idle values so they pulse for one cycle.
  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    epc_d      = epc_q;
    handler_d  = handler_q;
    mem_addr_d = mem_addr_q;
    mem_rd_d   = mem_rd_q;
    pc_wr_d    = 1'b0;
    pc_src_d   = PC_SRC_ALU_DIRECT;
`ifdef EXC_TIMEOUT_EN
    cnt_d      = cnt_q;
    fault_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        // An exception beats an rte presented in the same cycle; the rte is simply lost.
        if (enc_vld) begin
          cause_d = enc_cause;
          state_d = ST_SAVE;
        end else if (rte_i) begin
          pc_wr_d  = 1'b1;
          pc_src_d = PC_SRC_EPC;
        end
      end
      ST_SAVE: begin
        epc_d      = pc_in_i - PC_ADJUST;
        mem_addr_d = vec_for(cause_q);
        mem_rd_d   = 1'b1;
        state_d    = ST_FETCH;
`ifdef EXC_TIMEOUT_EN
        cnt_d      = 8'd0;
`endif
      end
      ST_FETCH: begin
        if (mem_valid_i) begin
          handler_d = sext8(mem_rdata_i);
          mem_rd_d  = 1'b0;
          pc_wr_d   = 1'b1;
          pc_src_d  = PC_SRC_MEM_SEXT;
          state_d   = ST_LOAD;
        end
`ifdef EXC_TIMEOUT_EN
        // Give up after TIMEOUT silent cycles; EPC keeps the value just saved.
        else if (cnt_q == TIMEOUT - 8'd1) begin
          mem_rd_d = 1'b0;
          fault_d  = 1'b1;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      ST_LOAD: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset aborts any sequence without a PC write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cause_q    <= CAUSE_NONE;
      epc_q      <= 32'd0;
      handler_q  <= 32'd0;
      mem_addr_q <= 32'd0;
      mem_rd_q   <= 1'b0;
      pc_wr_q    <= 1'b0;
      pc_src_q   <= PC_SRC_ALU_DIRECT;
      busy_q     <= 1'b0;
`ifdef EXC_TIMEOUT_EN
      cnt_q      <= 8'd0;
      fault_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cause_q    <= cause_d;
      epc_q      <= epc_d;
      handler_q  <= handler_d;
      mem_addr_q <= mem_addr_d;
      mem_rd_q   <= mem_rd_d;
      pc_wr_q    <= pc_wr_d;
      pc_src_q   <= pc_src_d;
      busy_q     <= busy_d;
`ifdef EXC_TIMEOUT_EN
      cnt_q      <= cnt_d;
      fault_q    <= fault_d;
`endif
    end
  end

  assign mem_rd_o       = mem_rd_q;
  assign mem_addr_o     = mem_addr_q;
  assign epc_out_o      = epc_q;
  assign handler_addr_o = handler_q;
  assign pc_src_sel_o   = pc_src_q;
  assign pc_wr_o        = pc_wr_q;
  assign exc_cause_o    = cause_q;
  assign busy_o         = busy_q;
`ifdef EXC_TIMEOUT_EN
  assign exc_fault_o    = fault_q;
`endif

endmodule

// File: tb/tb_exception_pc_ctrl.sv
// Directed bench for exception_pc_ctrl with a transaction-level reference model.
// Latency: n/a.
// Backpressure: mem_valid is driven by the stimulus to insert wait cycles.
module tb_exception_pc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exc_opcode = 1'b0, exc_ovf = 1'b0, exc_div0 = 1'b0, rte = 1'b0;
  logic [31:0] pc_in = 32'd0;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata = 8'd0;
  logic        mem_valid = 1'b0;
  logic [31:0] epc_out, handler_addr;
  logic [2:0]  pc_src_sel;
  logic        pc_wr;
  logic [1:0]  exc_cause;
  logic        busy;
`ifdef EXC_TIMEOUT_EN
  logic        exc_fault;
`endif

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  exception_pc_ctrl dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .exc_opcode_i   (exc_opcode),
    .exc_ovf_i      (exc_ovf),
    .exc_div0_i     (exc_div0),
    .rte_i          (rte),
    .pc_in_i        (pc_in),
    .mem_rd_o       (mem_rd),
    .mem_addr_o     (mem_addr),
    .mem_rdata_i    (mem_rdata),
    .mem_valid_i    (mem_valid),
    .epc_out_o      (epc_out),
    .handler_addr_o (handler_addr),
    .pc_src_sel_o   (pc_src_sel),
    .pc_wr_o        (pc_wr),
    .exc_cause_o    (exc_cause),
    .busy_o         (busy)
`ifdef EXC_TIMEOUT_EN
    ,
    .exc_fault_o    (exc_fault)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks an accepted exception by its age in cycles
  // and whether the handler byte has arrived, rather than by FSM state.
  logic        m_busy, m_rd, m_wr, m_fault;
  logic [31:0] m_epc, m_hand, m_addr;
  logic [2:0]  m_sel;
  logic [1:0]  m_cause;
  int          m_age, m_wait;
  bit          m_got;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 0; m_rd = 0; m_wr = 0; m_fault = 0;
      m_epc = 0; m_hand = 0; m_addr = 0; m_sel = 0; m_cause = 0;
      m_age = 0; m_wait = 0; m_got = 0;
    end else begin
      m_wr = 0; m_sel = 3'd0; m_fault = 0;
      if (!m_busy) begin
        if (exc_opcode || exc_ovf || exc_div0) begin
          m_cause = exc_opcode ? 2'd1 : (exc_ovf ? 2'd2 : 2'd3);
          m_busy = 1; m_age = 0; m_got = 0; m_wait = 0;
        end else if (rte) begin
          m_wr = 1; m_sel = 3'd4;
        end
      end else begin
        m_age++;
        if (m_age == 1) begin
          m_epc  = pc_in - 32'd4;
          m_addr = 32'd252 + 32'(m_cause);
          m_rd   = 1;
        end else if (m_got) begin
          m_busy = 0;
        end else if (mem_valid) begin
          m_hand = 32'($signed(mem_rdata));
          m_rd = 0; m_wr = 1; m_sel = 3'd3; m_got = 1;
        end else begin
          m_wait++;
`ifdef EXC_TIMEOUT_EN
          if (m_wait == 16) begin
            m_busy = 0; m_rd = 0; m_fault = 1;
          end
`endif
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("mem_rd", 32'(mem_rd), 32'(m_rd));
      chk("mem_addr", mem_addr, m_addr);
      chk("epc", epc_out, m_epc);
      chk("handler", handler_addr, m_hand);
      chk("pc_src_sel", 32'(pc_src_sel), 32'(m_sel));
      chk("pc_wr", 32'(pc_wr), 32'(m_wr));
      chk("cause", 32'(exc_cause), 32'(m_cause));
`ifdef EXC_TIMEOUT_EN
      chk("exc_fault", 32'(exc_fault), 32'(m_fault));
`endif
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_epc"}, epc_out, 32'd0);
    chk({tag, "_handler"}, handler_addr, 32'd0);
    chk({tag, "_sel"}, 32'(pc_src_sel), 32'd0);
    chk({tag, "_pc_wr"}, 32'(pc_wr), 32'd0);
    chk({tag, "_cause"}, 32'(exc_cause), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_vals("por");
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Reset asserted mid-FETCH: outputs clear at once and no PC write follows.
    exc_opcode = 1; pc_in = 32'h40;
    @(negedge clk); exc_opcode = 0;
    @(negedge clk);
    chk("t1_fetch_rd", 32'(mem_rd), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("t1_mid");
    mem_valid = 1; mem_rdata = 8'h55;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("t1_no_wr", 32'(pc_wr), 32'd0);
    end
    mem_valid = 0;

    // opcode and div0 together: opcode wins, div0 is never serviced.
    exc_opcode = 1; exc_div0 = 1; pc_in = 32'h1000;
    @(negedge clk); exc_opcode = 0; exc_div0 = 0;
    chk("t3_cause", 32'(exc_cause), 32'd1);
    @(negedge clk);
    chk("t3_addr", mem_addr, 32'd253);
    chk("t3_epc", epc_out, 32'h0000_0FFC);
    mem_valid = 1; mem_rdata = 8'h10;
    @(negedge clk); mem_valid = 0;
    chk("t3_wr", 32'(pc_wr), 32'd1);
    chk("t3_handler", handler_addr, 32'h0000_0010);
    repeat (2) @(negedge clk);
    chk("t3_idle", 32'(busy), 32'd0);
    chk("t3_cause_kept", 32'(exc_cause), 32'd1);

    // Overflow with two memory wait cycles: pc_wr lands 5 cycles after the request.
    exc_ovf = 1; pc_in = 32'h100;
    @(negedge clk); exc_ovf = 0;
    chk("t2_cause", 32'(exc_cause), 32'd2);
    @(negedge clk);
    chk("t2_addr", mem_addr, 32'd254);
    chk("t2_epc", epc_out, 32'h0000_00FC);
    @(negedge clk);
    @(negedge clk);
    chk("t2_wait_wr", 32'(pc_wr), 32'd0);
    mem_valid = 1; mem_rdata = 8'h80;
    @(negedge clk); mem_valid = 0;
    chk("t2_c5_wr", 32'(pc_wr), 32'd1);
    chk("t2_c5_sel", 32'(pc_src_sel), 32'd3);
    chk("t2_handler", handler_addr, 32'hFFFF_FF80);
    @(negedge clk);
    chk("t2_after_wr", 32'(pc_wr), 32'd0);
    chk("t2_after_sel", 32'(pc_src_sel), 32'd0);

    // rte from idle returns to EPC one cycle later.
    rte = 1;
    @(negedge clk); rte = 0;
    chk("t4_rte_wr", 32'(pc_wr), 32'd1);
    chk("t4_rte_sel", 32'(pc_src_sel), 32'd4);
    chk("t4_rte_epc", epc_out, 32'h0000_00FC);
    @(negedge clk);
    chk("t4_rte_off", 32'(pc_wr), 32'd0);
    // div0 and rte held while busy are ignored.
    exc_opcode = 1; pc_in = 32'h300;
    @(negedge clk); exc_opcode = 0; exc_div0 = 1; rte = 1;
    @(negedge clk);
    @(negedge clk);
    mem_valid = 1; mem_rdata = 8'h04;
    @(negedge clk); mem_valid = 0; exc_div0 = 0; rte = 0;
    chk("t4_load_sel", 32'(pc_src_sel), 32'd3);
    @(negedge clk);
    chk("t4_cause", 32'(exc_cause), 32'd1);
    @(negedge clk);
    chk("t4_idle", 32'(busy), 32'd0);

    // div0 and rte together with pc_in below the adjustment: EPC wraps, rte dropped.
    exc_div0 = 1; rte = 1; pc_in = 32'h2;
    @(negedge clk); exc_div0 = 0; rte = 0;
    chk("t5_no_rte", 32'(pc_wr), 32'd0);
    chk("t5_busy", 32'(busy), 32'd1);
    chk("t5_cause", 32'(exc_cause), 32'd3);
    @(negedge clk);
    chk("t5_epc", epc_out, 32'hFFFF_FFFE);
    chk("t5_addr", mem_addr, 32'd255);
    mem_valid = 1; mem_rdata = 8'h7F;
    @(negedge clk); mem_valid = 0;
    chk("t5_handler", handler_addr, 32'h0000_007F);
    repeat (2) @(negedge clk);

`ifdef EXC_TIMEOUT_EN
    // No mem_valid ever: fault after 16 FETCH cycles, no PC write.
    begin
      int n;
      exc_ovf = 1; pc_in = 32'h500;
      @(negedge clk); exc_ovf = 0;
      n = 1;
      while (busy && n < 40) begin
        @(negedge clk);
        n++;
      end
      chk("t6_cycles", 32'(n), 32'd18);
      chk("t6_fault", 32'(exc_fault), 32'd1);
      chk("t6_no_wr", 32'(pc_wr), 32'd0);
      chk("t6_epc", epc_out, 32'h0000_04FC);
      @(negedge clk);
      chk("t6_fault_off", 32'(exc_fault), 32'd0);
    end
`endif

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
